char_flusher: RTL and testbench
===============================

Name: char_flusher

Overview:
Sequential writer that drives the glyph LUT read interface. On a start request it walks flush_x/flush_y row-major over one character cell at a given origin and samples the glyph module's colour/enable answer for each position. It then issues registered pixel writes to the VGA framebuffer adapter. It sits between the game/text controller and the VGA adapter, with one char_* glyph instance wired to its flush outputs.

Parameters:
CELL_W, 10, cell width in pixels (x offsets 0..CELL_W-1)
CELL_H, 10, cell height in pixels (y offsets 0..CELL_H-1)
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are never plotted
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are never plotted
DRAW_BG, 0, 1 = also plot BG_COLOUR where glyph_enable=0 (erase/redraw cell)
BG_COLOUR, 6'h00, background colour used when DRAW_BG=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request to draw one cell; sampled only in IDLE
origin_x  in  8  cell top-left x; latched on accepted start
origin_y  in  8  cell top-left y; latched on accepted start
glyph_colour  in  6  colour from glyph module for current flush position (combinational)
glyph_enable  in  1  glyph pixel present at current flush position
flush_x  out  8  absolute x query to glyph module
flush_y  out  8  absolute y query to glyph module
vga_x  out  8  pixel write x
vga_y  out  8  pixel write y
vga_colour  out  6  pixel write colour
vga_plot  out  1  pixel write strobe, one cycle per pixel
busy  out  1  high while scanning
done  out  1  one-cycle pulse at end of cell

Behaviour:
- Reset: state IDLE; flush_x, flush_y, vga_x, vga_y, vga_colour = 0; vga_plot, busy, done = 0. Reset is honoured in any state, including mid-scan. No further plots after the reset edge, and no done.
- States: IDLE, SCAN, DONE.
- IDLE: busy=0. On start=1 at a clock edge: latch origin, dx=dy=0, go to SCAN. flush_x/flush_y hold their last value while idle.
- SCAN: busy=1. flush_x = origin_x+dx and flush_y = origin_y+dy, both driven from registers.
  - Order is row-major: dx increments each cycle; at dx=CELL_W-1, dx wraps to 0 and dy increments.
  - Exactly CELL_W*CELL_H cycles in SCAN. After the cycle with dx=CELL_W-1 and dy=CELL_H-1, go to DONE.
- Pixel pipeline, one-cycle latency: at the end of each SCAN cycle the registers load vga_x<=flush_x, vga_y<=flush_y, and vga_colour<=glyph_colour (or BG_COLOUR when !glyph_enable and DRAW_BG=1).
  - vga_plot <= (glyph_enable | DRAW_BG) & !clip.
  - In non-SCAN cycles, vga_plot <= 0 and the coordinate and colour registers hold.
- Clipping: origin+offset is computed at 9 bits. clip=1 if the sum is >= 256 (carry), or x >= SCREEN_W, or y >= SCREEN_H. The 8-bit flush outputs carry the wrapped low bits, but clipped pixels are never plotted.
- DONE: lasts one cycle; done=1 and busy=0. The last pixel's vga_plot, if any, coincides with this cycle. Then go to IDLE.
- start while in SCAN or DONE is ignored, not queued. Origin inputs are don't-care except at the accepted start edge.
- Timing: start accepted at edge 0 → SCAN during cycles 1..CELL_W*CELL_H → done high in cycle CELL_W*CELL_H+1.

Decomposition:
- Shared package: CELL_W/CELL_H defaults, SCREEN_W/SCREEN_H, the state enum {IDLE, SCAN, DONE}, and the 6-bit colour width constant.
- No sub-module required. The dx/dy cell counter may optionally be split into char_scan_counter (inputs clear/advance, outputs dx, dy, last).

Test Plan:
- U glyph (enable at x-offset 2 and 7 for rows 0..8; offsets 3..6 on row 9; colour 3F), origin (10,20), start pulse → exactly 22 vga_plot pulses; first at (12,20), last at (16,29); all colour 3F. done in cycle 101 after the start edge; busy high for cycles 1..100.
- Same glyph, origin (155,0) → only x=157 column plotted (9 plots at y=0..8), plus (158,9) and (159,9) on row 9; 11 plots total; x >= 160 never plotted.
- Origin (250,0) → offset 7 sums to 257 (carry) and is not plotted even though flush_x=1. Only columns 252 (clipped by SCREEN_W) … → 0 plots; done still pulses at cycle 101.
- DRAW_BG=1, BG_COLOUR=00, origin (0,0) → 100 plots: 22 with colour 3F, 78 with colour 00. Scan order matches row-major.
- Reset asserted at cycle 40 of a scan → next cycle vga_plot=0, busy=0, done never pulses. A subsequent start at origin (0,0) produces a full, correct 22-plot cell.
- start held high continuously → a new cell begins every 102 cycles (IDLE→SCAN at edge after DONE). start pulses during SCAN or DONE produce no extra cell.

Source files
------------

// File: rtl/char_flusher_pkg.sv
// Shared definitions for the character-cell flusher.
//   - Default cell and screen geometry
//   - Colour width used by the glyph and VGA colour buses
//   - Scan FSM state encoding
package char_flusher_pkg;

    localparam int COLOUR_W     = 6;
    localparam int CELL_W_DEF   = 10;
    localparam int CELL_H_DEF   = 10;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/char_flusher_if.sv
// Bus bundle between the text controller, the glyph LUT and the VGA adapter.
//   start/origin_*   : cell draw request from the controller
//   glyph_*          : combinational answer from the glyph module
//   flush_*          : position query to the glyph module
//   vga_*            : registered pixel write to the framebuffer adapter
//   busy/done        : scan status
// modport slave  : the flusher side
// modport master : the surrounding system (controller + glyph + adapter)
interface char_flusher_if;
    import char_flusher_pkg::*;

    logic                start;
    logic [7:0]          origin_x;
    logic [7:0]          origin_y;
    logic [COLOUR_W-1:0] glyph_colour;
    logic                glyph_enable;
    logic [7:0]          flush_x;
    logic [7:0]          flush_y;
    logic [7:0]          vga_x;
    logic [7:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                done;

    modport slave (
        input  start, origin_x, origin_y, glyph_colour, glyph_enable,
        output flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport master (
        output start, origin_x, origin_y, glyph_colour, glyph_enable,
        input  flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

endinterface

// File: rtl/char_flusher.sv
// Character-cell flusher: walks one CELL_W x CELL_H cell row-major, queries the
// glyph module at each absolute position and turns its answer into one
// registered VGA pixel write per visible lit (or background) pixel.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : char_flusher_if.slave (request, glyph query/answer, VGA write, status)
module char_flusher
    import char_flusher_pkg::*;
#(
    parameter int                  CELL_W    = CELL_W_DEF,
    parameter int                  CELL_H    = CELL_H_DEF,
    parameter int                  SCREEN_W  = SCREEN_W_DEF,
    parameter int                  SCREEN_H  = SCREEN_H_DEF,
    parameter bit                  DRAW_BG   = 1'b0,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic           clk,
    input  logic           reset,
    char_flusher_if.slave  bus
);

    localparam int DXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int DYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    state_e              state_q, state_d;
    logic [7:0]          ox_q, ox_d, oy_q, oy_d;
    logic [DXW-1:0]      dx_q, dx_d;
    logic [DYW-1:0]      dy_q, dy_d;
    // 9-bit absolute position: bit 8 is the carry out of origin+offset
    logic [8:0]          fx_q, fx_d, fy_q, fy_d;
    logic [7:0]          vga_x_q, vga_x_d, vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
    logic                vga_plot_q, vga_plot_d;

    logic last_col, last_row, clip;

    assign last_col = (dx_q == DXW'(CELL_W - 1));
    assign last_row = (dy_q == DYW'(CELL_H - 1));
    // A carried sum is >= 256, so the 9-bit compare also covers wrap-around
    assign clip     = (fx_q >= 9'(SCREEN_W)) || (fy_q >= 9'(SCREEN_H));

    always_comb begin
        state_d      = state_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        fx_d         = fx_q;
        fy_d         = fy_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    ox_d    = bus.origin_x;
                    oy_d    = bus.origin_y;
                    dx_d    = '0;
                    dy_d    = '0;
                    fx_d    = {1'b0, bus.origin_x};
                    fy_d    = {1'b0, bus.origin_y};
                end
            end
            SCAN: begin
                // Capture the glyph answer for the position on flush_x/flush_y now
                vga_x_d      = fx_q[7:0];
                vga_y_d      = fy_q[7:0];
                vga_colour_d = (!bus.glyph_enable && DRAW_BG) ? BG_COLOUR : bus.glyph_colour;
                vga_plot_d   = (bus.glyph_enable | DRAW_BG) & ~clip;

                if (last_col) begin
                    dx_d = '0;
                    if (last_row) begin
                        dy_d    = '0;
                        state_d = DONE;
                    end else begin
                        dy_d = dy_q + DYW'(1);
                    end
                end else begin
                    dx_d = dx_q + DXW'(1);
                end

                // Position only advances while scanning continues, so the query
                // lines keep the last pixel's position once the cell is finished
                if (state_d == SCAN) begin
                    fx_d = 9'(ox_q) + 9'(dx_d);
                    fy_d = 9'(oy_q) + 9'(dy_d);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ox_q         <= '0;
            oy_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            fx_q         <= '0;
            fy_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            fx_q         <= fx_d;
            fy_q         <= fy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign bus.flush_x    = fx_q[7:0];
    assign bus.flush_y    = fy_q[7:0];
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = (state_q == SCAN);
    assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_char_flusher.sv
// Self-checking bench for char_flusher: two instances (foreground only, and
// background redraw) driven by a "U" glyph model; expected plots are queued
// from an independent geometry model and matched against observed writes.
module tb_char_flusher;
    import char_flusher_pkg::*;

    typedef struct packed {
        logic [15:0] cyc;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [5:0]  c;
    } pix_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    char_flusher_if if0();
    char_flusher_if if1();

    char_flusher #(.DRAW_BG(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    char_flusher #(.DRAW_BG(1'b1), .BG_COLOUR(6'h00)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    logic [7:0] g_ox0 = 8'd0, g_oy0 = 8'd0, g_ox1 = 8'd0, g_oy1 = 8'd0;

    function automatic logic glyph_en(input logic [7:0] dx, input logic [7:0] dy);
        return ((dy <= 8'd8) && (dx == 8'd2 || dx == 8'd7)) ||
               ((dy == 8'd9) && (dx >= 8'd3) && (dx <= 8'd6));
    endfunction

    assign if0.glyph_enable = glyph_en(8'(if0.flush_x - g_ox0), 8'(if0.flush_y - g_oy0));
    assign if0.glyph_colour = if0.glyph_enable ? 6'h3F : 6'h15;
    assign if1.glyph_enable = glyph_en(8'(if1.flush_x - g_ox1), 8'(if1.flush_y - g_oy1));
    assign if1.glyph_colour = if1.glyph_enable ? 6'h3F : 6'h15;

    int   n_cmp = 0;
    int   n_bad = 0;
    pix_t exp_q[$];
    pix_t obs_q[$];
    int   done_q[$];
    logic busy_log [0:299];
    logic plot_log [0:299];
    logic [7:0] fx_log [0:299];
    int   busy_n, busy_first, busy_last;

    // Expected plots for one cell; base is the start-edge cycle of that cell
    task automatic push_expected(input int ox, input int oy, input bit bg, input int base);
        for (int dy = 0; dy < 10; dy++) begin
            for (int dx = 0; dx < 10; dx++) begin
                int  sx, sy;
                logic en;
                sx = ox + dx;
                sy = oy + dy;
                en = glyph_en(8'(dx), 8'(dy));
                if ((en || bg) && sx < 160 && sy < 120)
                    exp_q.push_back(pix_t'{16'(base + dy*10 + dx + 2), 8'(sx), 8'(sy),
                                           en ? 6'h3F : 6'h00});
            end
        end
    endtask

    // Drive one start on instance sel and record ncyc cycles of outputs.
    // start stays high through cycle 'hold'; extra one-cycle pulses at pa/pb;
    // reset asserted for the edge ending cycle rst_at (0 = none).
    task automatic run_cell(input int sel, input logic [7:0] ox, input logic [7:0] oy,
                            input int ncyc, input int hold, input int pa, input int pb,
                            input int rst_at);
        logic p, b, d, st;
        logic [7:0] vx, vy, fx;
        logic [5:0] vc;
        obs_q.delete();
        done_q.delete();
        busy_n = 0; busy_first = -1; busy_last = -1;
        if (sel == 0) begin
            g_ox0 = ox; g_oy0 = oy; if0.origin_x = ox; if0.origin_y = oy; if0.start = 1'b1;
        end else begin
            g_ox1 = ox; g_oy1 = oy; if1.origin_x = ox; if1.origin_y = oy; if1.start = 1'b1;
        end
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            if (sel == 0) begin
                p = if0.vga_plot; b = if0.busy; d = if0.done;
                vx = if0.vga_x; vy = if0.vga_y; vc = if0.vga_colour; fx = if0.flush_x;
            end else begin
                p = if1.vga_plot; b = if1.busy; d = if1.done;
                vx = if1.vga_x; vy = if1.vga_y; vc = if1.vga_colour; fx = if1.flush_x;
            end
            busy_log[cyc] = b;
            plot_log[cyc] = p;
            fx_log[cyc]   = fx;
            if (p) obs_q.push_back(pix_t'{16'(cyc), vx, vy, vc});
            if (d) done_q.push_back(cyc);
            if (b) begin
                busy_n++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            st = (cyc <= hold) || (cyc == pa) || (cyc == pb);
            if (sel == 0) if0.start = st; else if1.start = st;
            reset = (cyc == rst_at);
            @(posedge clk); #1;
        end
        if0.start = 1'b0;
        if1.start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({if0.flush_x, if0.flush_y, if0.vga_x, if0.vga_y, if0.vga_colour,
             if0.vga_plot, if0.busy, if0.done} !== '0) begin
            n_bad++;
            $display("FAIL reset_dut0: got fx=%0d fy=%0d vx=%0d vy=%0d c=%h p=%b b=%b d=%b, want all 0",
                     if0.flush_x, if0.flush_y, if0.vga_x, if0.vga_y, if0.vga_colour,
                     if0.vga_plot, if0.busy, if0.done);
        end
        n_cmp++;
        if ({if1.flush_x, if1.vga_colour, if1.vga_plot, if1.busy, if1.done} !== '0) begin
            n_bad++;
            $display("FAIL reset_dut1: got fx=%0d c=%h p=%b b=%b d=%b, want all 0",
                     if1.flush_x, if1.vga_colour, if1.vga_plot, if1.busy, if1.done);
        end
    endtask

    task automatic test_u_glyph();
        int dc;
        exp_q.delete();
        push_expected(10, 20, 1'b0, 0);
        run_cell(0, 8'd10, 8'd20, 110, 0, 0, 0, 0);
        n_cmp++;
        if (obs_q.size() !== 22) begin
            n_bad++; $display("FAIL u_count: got %0d plots, want 22", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++; $display("FAIL u_pixel: got cyc=%0d (%0d,%0d) c=%h, want cyc=%0d (%0d,%0d) c=%h",
                                  o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
            end
        end
        dc = (done_q.size() == 1) ? done_q[0] : -1;
        n_cmp++;
        if (dc !== 101) begin n_bad++; $display("FAIL u_done: got cycle %0d (pulses %0d), want 101", dc, done_q.size()); end
        n_cmp++;
        if (busy_n !== 100 || busy_first !== 1 || busy_last !== 100) begin
            n_bad++; $display("FAIL u_busy: got %0d cycles %0d..%0d, want 100 cycles 1..100", busy_n, busy_first, busy_last);
        end
    endtask

    task automatic test_clip_right();
        exp_q.delete();
        push_expected(155, 0, 1'b0, 0);
        run_cell(0, 8'd155, 8'd0, 110, 0, 0, 0, 0);
        n_cmp++;
        if (obs_q.size() !== 11) begin
            n_bad++; $display("FAIL clip_count: got %0d plots, want 11", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++; $display("FAIL clip_pixel: got cyc=%0d (%0d,%0d) c=%h, want cyc=%0d (%0d,%0d) c=%h",
                                  o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
            end
        end
    endtask

    task automatic test_carry();
        int dc;
        run_cell(0, 8'd250, 8'd0, 110, 0, 0, 0, 0);
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_bad++; $display("FAIL carry_count: got %0d plots, want 0", obs_q.size());
        end
        n_cmp++;
        if (fx_log[8] !== 8'd1) begin
            n_bad++; $display("FAIL carry_flush_x: got %0d at cycle 8, want 1", fx_log[8]);
        end
        dc = (done_q.size() == 1) ? done_q[0] : -1;
        n_cmp++;
        if (dc !== 101) begin n_bad++; $display("FAIL carry_done: got cycle %0d, want 101", dc); end
    endtask

    task automatic test_draw_bg();
        int n3f;
        exp_q.delete();
        push_expected(0, 0, 1'b1, 0);
        run_cell(1, 8'd0, 8'd0, 110, 0, 0, 0, 0);
        n3f = 0;
        foreach (obs_q[i]) if (obs_q[i].c == 6'h3F) n3f++;
        n_cmp++;
        if (obs_q.size() !== 100 || n3f !== 22) begin
            n_bad++; $display("FAIL bg_count: got %0d plots (%0d fg), want 100 (22 fg)", obs_q.size(), n3f);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++; $display("FAIL bg_pixel: got cyc=%0d (%0d,%0d) c=%h, want cyc=%0d (%0d,%0d) c=%h",
                                  o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int n_pre, n_late;
        exp_q.delete();
        push_expected(0, 0, 1'b0, 0);
        n_pre = 0;
        foreach (exp_q[i]) if (exp_q[i].cyc <= 40) n_pre++;
        run_cell(0, 8'd0, 8'd0, 150, 0, 0, 0, 40);
        n_late = 0;
        foreach (obs_q[i]) if (obs_q[i].cyc > 40) n_late++;
        n_cmp++;
        if (plot_log[41] !== 1'b0 || busy_log[41] !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_next: got plot=%b busy=%b, want 0 0", plot_log[41], busy_log[41]);
        end
        n_cmp++;
        if (done_q.size() !== 0 || n_late !== 0) begin
            n_bad++; $display("FAIL rst_mid_quiet: got %0d done, %0d late plots, want 0 0", done_q.size(), n_late);
        end
        n_cmp++;
        if (obs_q.size() !== n_pre) begin
            n_bad++; $display("FAIL rst_mid_pre: got %0d plots before reset, want %0d", obs_q.size(), n_pre);
        end
        // A fresh cell after the aborted one must be complete
        exp_q.delete();
        push_expected(0, 0, 1'b0, 0);
        run_cell(0, 8'd0, 8'd0, 110, 0, 0, 0, 0);
        n_cmp++;
        if (obs_q.size() !== 22) begin
            n_bad++; $display("FAIL rst_after_count: got %0d plots, want 22", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++; $display("FAIL rst_after_pixel: got cyc=%0d (%0d,%0d) c=%h, want cyc=%0d (%0d,%0d) c=%h",
                                  o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d0, d1;
        exp_q.delete();
        push_expected(10, 20, 1'b0, 0);
        push_expected(10, 20, 1'b0, 102);
        run_cell(0, 8'd10, 8'd20, 230, 102, 0, 0, 0);
        d0 = (done_q.size() == 2) ? done_q[0] : -1;
        d1 = (done_q.size() == 2) ? done_q[1] : -1;
        n_cmp++;
        if (d0 !== 101 || d1 !== 203) begin
            n_bad++; $display("FAIL b2b_done: got %0d pulses at %0d,%0d, want 101,203", done_q.size(), d0, d1);
        end
        n_cmp++;
        if (busy_n !== 200 || busy_log[102] !== 1'b0 || busy_log[103] !== 1'b1) begin
            n_bad++; $display("FAIL b2b_busy: got %0d cycles, c102=%b c103=%b, want 200 0 1",
                              busy_n, busy_log[102], busy_log[103]);
        end
        n_cmp++;
        if (obs_q.size() !== 44) begin
            n_bad++; $display("FAIL b2b_count: got %0d plots, want 44", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++; $display("FAIL b2b_pixel: got cyc=%0d (%0d,%0d) c=%h, want cyc=%0d (%0d,%0d) c=%h",
                                  o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
            end
        end
    endtask

    task automatic test_ignored_start();
        int dc;
        // Pulses land in SCAN (cycle 50) and in DONE (cycle 101)
        run_cell(0, 8'd10, 8'd20, 230, 0, 50, 101, 0);
        dc = (done_q.size() == 1) ? done_q[0] : -1;
        n_cmp++;
        if (dc !== 101) begin n_bad++; $display("FAIL ign_done: got %0d pulses, first %0d, want 1 at 101", done_q.size(), dc); end
        n_cmp++;
        if (busy_n !== 100 || obs_q.size() !== 22) begin
            n_bad++; $display("FAIL ign_cells: got busy=%0d plots=%0d, want 100 22", busy_n, obs_q.size());
        end
    endtask

    initial begin
        if0.start = 1'b0; if0.origin_x = 8'd0; if0.origin_y = 8'd0;
        if1.start = 1'b0; if1.origin_x = 8'd0; if1.origin_y = 8'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_u_glyph();
        test_clip_right();
        test_carry();
        test_draw_bg();
        test_reset_mid_scan();
        test_back_to_back();
        test_ignored_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
